// File: rtl/xls_pipe_pkg.sv
// Shared types and helpers for the XLS valid-only pipeline credit sink.
// The counter widths and the credit update encoding used by the top and the FIFO are defined here.
package xls_pipe_pkg;

    localparam int MIN_LATENCY = 1;

    typedef enum logic [1:0] {
        CREDIT_HOLD,
        CREDIT_TAKE,
        CREDIT_GIVE
    } credit_op_e;

    // Bits needed to hold any value in 0..depth.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // An issue and a pop in the same cycle cancel out.
    function automatic credit_op_e credit_op(input logic issue, input logic pop);
        if (issue && !pop) begin
            return CREDIT_TAKE;
        end
        if (pop && !issue) begin
            return CREDIT_GIVE;
        end
        return CREDIT_HOLD;
    endfunction

endpackage

// File: rtl/xls_pipe_result_fifo.sv
// Result FIFO for the credit sink: circular buffer with registered head and no fall-through.
// A push into a full FIFO without a simultaneous pop drops the data and sets a sticky overflow flag.
module xls_pipe_result_fifo
    import xls_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = credit_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    assign do_pop  = pop && !empty;
    // When full, the slot being popped this cycle is the one the push overwrites.
    assign do_push = push && (!full || do_pop);

    // NOTE: storage has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/xls_pipe_credit_sink.sv
// Consumer-side adapter for a valid-only XLS pipeline: meters issue with credits and
// re-presents every pipeline result as a ready/valid stream through a local FIFO.
module xls_pipe_credit_sink
    import xls_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  pipe_input_valid,
    input  logic                  pipe_output_valid,
    input  logic [DATA_WIDTH-1:0] pipe_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  idle,
    output logic                  overflow
);

    localparam int CRED_W  = credit_width(DEPTH);
    localparam int FLUSH_W = $clog2(LATENCY + 1);
    localparam logic [CRED_W-1:0]  MAX_CREDITS  = CRED_W'(DEPTH);
    localparam logic [FLUSH_W-1:0] FLUSH_CYCLES = FLUSH_W'(LATENCY);

    if (LATENCY < MIN_LATENCY) begin : g_bad_latency
        $error("xls_pipe_credit_sink: LATENCY must be >= %0d", MIN_LATENCY);
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("xls_pipe_credit_sink: DEPTH must be >= 1");
    end

    logic [CRED_W-1:0]  credits;
    logic [CRED_W-1:0]  credits_next;
    logic [FLUSH_W-1:0] flush_cnt;
    logic               flush_done;
    logic               issue;
    logic               pop;
    logic               fifo_push;
    logic               fifo_full;
    logic               fifo_empty;
    credit_op_e         credit_cmd;

    assign flush_done       = (flush_cnt == '0);
    assign in_ready         = flush_done && (credits != '0);
    assign issue            = in_valid && in_ready;
    assign pipe_input_valid = issue;
    assign out_valid        = !fifo_empty;
    assign pop              = out_valid && out_ready;
    assign idle             = (credits == MAX_CREDITS) && flush_done;

    // Pipeline valid registers are not reset, so results are ignored until the flush window closes.
    assign fifo_push = pipe_output_valid && flush_done;

    assign credit_cmd = credit_op(issue, pop);

    // NOTE: every always_comb target gets its default first so no path can infer a latch.
    always_comb begin
        credits_next = credits;
        unique case (credit_cmd)
            CREDIT_TAKE: if (credits != '0)          credits_next = credits - 1'b1;
            CREDIT_GIVE: if (credits != MAX_CREDITS) credits_next = credits + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits   <= MAX_CREDITS;
            flush_cnt <= FLUSH_CYCLES;
        end else begin
            credits <= credits_next;
            if (!flush_done) begin
                flush_cnt <= flush_cnt - 1'b1;
            end
        end
    end

    xls_pipe_result_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (pipe_out),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (out_data),
        .overflow  (overflow)
    );

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        credits <= MAX_CREDITS)
        else $error("credit counter above DEPTH");

    a_credit_over: assert property (@(posedge clk) disable iff (rst)
        !(credit_cmd == CREDIT_GIVE && credits == MAX_CREDITS))
        else $error("credit returned with none outstanding");

    a_credit_under: assert property (@(posedge clk) disable iff (rst)
        !(credit_cmd == CREDIT_TAKE && credits == '0))
        else $error("issue with no credit available");

    // Only reachable when the pipeline delivers a result that was never issued.
    a_no_drop: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && fifo_full && !pop))
        else $warning("pipeline result dropped: result FIFO full");

endmodule

// File: tb/tb_xls_pipe_credit_sink.sv
// Directed bench for xls_pipe_credit_sink with a 2-stage valid-only pipeline model whose
// valid registers are deliberately left out of reset.
module tb_xls_pipe_credit_sink;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          pipe_input_valid;
    logic          pipe_output_valid;
    logic [DW-1:0] pipe_out;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          idle;
    logic          overflow;

    logic          const_mode;
    logic          force_pv;
    int unsigned   issue_cnt = 0;
    int unsigned   tag_base;
    logic [1:0]    pv = '0;
    logic [DW-1:0] pd [2];

    int vectors     = 0;
    int miscompares = 0;

    xls_pipe_credit_sink #(
        .DATA_WIDTH (DW),
        .LATENCY    (2),
        .DEPTH      (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .pipe_input_valid  (pipe_input_valid),
        .pipe_output_valid (pipe_output_valid),
        .pipe_out          (pipe_out),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .idle              (idle),
        .overflow          (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipeline model: LATENCY=2, ignores rst; data is a constant or the issue index.
    always @(posedge clk) begin
        pv[0] <= pipe_input_valid;
        pd[0] <= const_mode ? 32'h0000_002a : (issue_cnt - tag_base);
        pv[1] <= pv[0];
        pd[1] <= pd[0];
        if (pipe_input_valid) issue_cnt <= issue_cnt + 1;
    end

    assign pipe_output_valid = pv[1] | force_pv;
    assign pipe_out          = force_pv ? 32'hdead_beef : pd[1];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int pops;
        int exp_val;
        int first_cyc;
        int last_cyc;

        rst        = 1'b1;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        const_mode = 1'b1;
        force_pv   = 1'b0;
        tag_base   = 0;

        // Scenario 1: reset values, flush window, first-result latency.
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_pipe_input_valid", pipe_input_valid, 0);
        check("rst_idle", idle, 0);
        check("rst_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("flush_cycle0_in_ready", in_ready, 0);
        @(negedge clk);
        check("flush_cycle1_in_ready", in_ready, 0);
        @(negedge clk);
        check("ready_after_flush", in_ready, 1);
        check("first_issue", pipe_input_valid, 1);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("issue_to_out_latency", n, 3);
        check("first_out_data", out_data, 32'h0000_002a);

        // Scenario 2: downstream stalled, credits run out after 4 issues.
        repeat (5) @(negedge clk);
        check("fill_issue_count", issue_cnt, 4);
        check("fill_in_ready", in_ready, 0);
        check("fill_overflow", overflow, 0);
        check("fill_idle", idle, 0);
        check("fill_out_valid", out_valid, 1);

        // Scenario 3: one pop returns one credit, exactly one more issue follows.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("credit_returned_in_ready", in_ready, 1);
        @(negedge clk);
        check("credit_spent_in_ready", in_ready, 0);
        repeat (4) @(negedge clk);
        check("one_more_issue", issue_cnt, 5);
        check("refill_overflow", overflow, 0);

        // Scenario 5: uncredited result into the full FIFO.
        force_pv = 1'b1;
        @(negedge clk);
        force_pv = 1'b0;
        check("overflow_set", overflow, 1);
        check("overflow_out_valid", out_valid, 1);
        check("overflow_head_kept", out_data, 32'h0000_002a);
        repeat (3) @(negedge clk);
        check("overflow_sticky", overflow, 1);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 20 && out_valid; i++) begin
            check("drain_data", out_data, 32'h0000_002a);
            pops++;
            @(negedge clk);
        end
        check("drain_count", pops, 4);
        check("idle_after_drain", idle, 1);

        // Scenario 4: steady stream, one issue and one pop per cycle, data in order.
        const_mode = 1'b0;
        tag_base   = issue_cnt;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        exp_val    = 0;
        first_cyc  = 0;
        last_cyc   = 0;
        for (int cyc = 0; cyc < 400 && exp_val < 100; cyc++) begin
            @(negedge clk);
            if (issue_cnt - tag_base == 100) in_valid = 1'b0;
            if (out_valid) begin
                check("stream_data", out_data, exp_val);
                if (exp_val == 50) check("steady_in_ready", in_ready, 1);
                if (exp_val == 0) first_cyc = cyc;
                last_cyc = cyc;
                exp_val++;
            end
        end
        check("stream_count", exp_val, 100);
        check("stream_one_per_cycle", last_cyc - first_cyc, 99);
        repeat (3) @(negedge clk);
        check("stream_idle", idle, 1);
        check("stream_empty", out_valid, 0);

        // Scenario 6: reset with 3 results queued (one uncredited) and 2 in flight.
        const_mode = 1'b1;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        @(negedge clk);
        force_pv = 1'b1;
        @(negedge clk);
        force_pv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_out_valid", out_valid, 1);
        check("pre_rst_in_ready", in_ready, 0);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_idle", idle, 0);
        check("mid_rst_overflow", overflow, 0);
        @(negedge clk);
        rst      = 1'b0;
        force_pv = 1'b1;
        #1 check("post_rst_flush0", in_ready, 0);
        @(negedge clk);
        check("post_rst_flush1", in_ready, 0);
        check("post_rst_no_push1", out_valid, 0);
        @(negedge clk);
        force_pv = 1'b0;
        check("post_rst_no_push2", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_idle", idle, 1);
        check("post_rst_overflow", overflow, 0);
        @(negedge clk);
        check("post_rst_still_empty", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
